decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I decode stage between fetch and execute.
- Accepts instruction+PC under a valid/ready handshake and decodes all RV32I base opcodes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- Flags illegal encodings.
- Presents decoded fields from output registers, with an optional skid buffer so in_ready carries no combinational path from out_ready.

Parameters:
- XLEN, 32, width of PC and immediate outputs; immediates are sign-extended to XLEN.
- SKID, 1, 1 = two-entry skid buffer, in_ready registered; 0 = single register, in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  kill all held and incoming instructions this cycle
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts instruction
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  passed-through PC
- out_alu_op  out  4  0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu
- out_alu_src_imm  out  1  operand B is imm
- out_alu_src_pc  out  1  operand A is PC (AUIPC, JAL)
- out_reg_write  out  1  writes rd
- out_mem_read  out  1  load
- out_mem_write  out  1  store
- out_mem_width  out  2  00 byte, 01 half, 10 word
- out_mem_unsigned  out  1  LBU/LHU
- out_is_branch  out  1  conditional branch
- out_branch_type  out  3  funct3 of the branch
- out_is_jump  out  1  JAL
- out_is_jalr  out  1  JALR
- out_rs1, out_rs2, out_rd  out  5 each  register fields
- out_rs1_used, out_rs2_used  out  1 each  operand read required
- out_imm  out  XLEN  I/S/B/U/J immediate per opcode; 0 for R-type
- out_illegal  out  1  illegal encoding

Behaviour:

Reset:
- out_valid = 0.
- All payload outputs = 0.
- Skid entry empty.
- in_ready = 1 with SKID = 1, and 1 with SKID = 0 (since out_valid = 0).

Latency and handshake:
- Latency 1 cycle: an accepted instruction appears on the outputs the next cycle.
- Handshakes fire on valid && ready.
- Outputs are held stable while out_valid && !out_ready.

SKID = 1 path:
- in_ready = !skid_valid (registered).
- Input accepted while the main register is full and stalled goes to the skid entry.
- When the main register drains, the skid entry moves to main that cycle and skid_valid clears.
- Full throughput is sustained with out_ready = 1.

Flush:
- Synchronous; clears out_valid and skid_valid.
- An input handshake in the same cycle is discarded.
- Flush overrides any simultaneous output handshake.
- Payload is not cleared by flush.

ALU op decode:
- R-type: ADD/SUB use funct7[5]; funct3 101 selects SRL/SRA on funct7[5].
- I-ALU: same mapping as R-type. No SUBI: funct3 000 is always add. SRLI/SRAI use funct7[5].
- LOAD, STORE, JALR, AUIPC, JAL: alu_op add.
- LUI: alu_op add, rs1 forced to 0.

Register usage:
- reg_write = 1 for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC, and only when rd != 0.
- rs1_used = 0 for LUI, AUIPC, JAL.
- rs2_used = 1 only for R, STORE, BRANCH.

Illegal encodings:
- Conditions:
  - instr[1:0] != 11
  - unknown opcode
  - R-type funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101}
  - SLLI funct7 != 0
  - SRLI/SRAI funct7 not in {0000000, 0100000}
  - load funct3 in {011, 110, 111}
  - store funct3 > 010
  - branch funct3 in {010, 011}
  - JALR funct3 != 000
- Response:
  - out_illegal = 1.
  - All write/mem/branch/jump controls = 0.
  - The instruction still flows through the handshake.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with out_ready = 1 → next cycle out_valid = 1, alu_op 0000, rs1 = 1, rs2 = 2, rd = 3, reg_write = 1, imm = 0.
- SRAI x5,x5,3 (0x4032D293) → alu_op 0111, alu_src_imm = 1, imm = 0x403; SRLI 0x0032D293 → alu_op 0110.
- BEQ with imm -4 (0xFE000EE3) → is_branch = 1, branch_type 000, imm = 0xFFFFFFFC, reg_write = 0, rs2_used = 1.
- SKID = 1, out_ready held 0, three back-to-back in_valid → two accepted, in_ready = 0 on the third; release out_ready → both emerge in order on consecutive cycles, third accepted.
- flush asserted while main and skid are full and in_valid = 1 → next cycle out_valid = 0, in_ready = 1, nothing emitted.
- Word 0x00000000 and 0x0000707F → out_illegal = 1, all controls 0. Assert rst_n low mid-stall → out_valid = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32I decode stage with valid/ready handshake,
//            illegal-encoding detection and an optional two-entry skid buffer.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_alu_op,
    output logic            out_alu_src_imm,
    output logic            out_alu_src_pc,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [1:0]      out_mem_width,
    output logic            out_mem_unsigned,
    output logic            out_is_branch,
    output logic [2:0]      out_branch_type,
    output logic            out_is_jump,
    output logic            out_is_jalr,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      alu_op;
        logic            alu_src_imm;
        logic            alu_src_pc;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [1:0]      mem_width;
        logic            mem_unsigned;
        logic            is_branch;
        logic [2:0]      branch_type;
        logic            is_jump;
        logic            is_jalr;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_used;
        logic            rs2_used;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } payload_t;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm32;
    payload_t    w_dec;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u  = {in_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // alt selects SUB at funct3 000 and SRA at funct3 101
    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_map = alt ? 4'b0001 : 4'b0000;
            3'b001:  alu_map = 4'b0101;
            3'b010:  alu_map = 4'b1000;
            3'b011:  alu_map = 4'b1001;
            3'b100:  alu_map = 4'b0010;
            3'b101:  alu_map = alt ? 4'b0111 : 4'b0110;
            3'b110:  alu_map = 4'b0011;
            default: alu_map = 4'b0100;
        endcase
    endfunction

    always_comb begin
        w_dec     = '0;
        w_imm32   = '0;
        w_dec.pc  = in_pc;
        w_dec.rs1 = in_instr[19:15];
        w_dec.rs2 = in_instr[24:20];
        w_dec.rd  = in_instr[11:7];
        case (w_opcode)
            c_OP_R: begin
                w_dec.alu_op    = alu_map(w_f3, w_f7[5]);
                w_dec.reg_write = 1'b1;
                w_dec.rs1_used  = 1'b1;
                w_dec.rs2_used  = 1'b1;
                w_dec.illegal   = !((w_f7 == 7'b0) ||
                                    ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            end
            c_OP_IMM: begin
                w_dec.alu_op      = alu_map(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.rs1_used    = 1'b1;
                w_imm32           = w_imm_i;
                w_dec.illegal     = ((w_f3 == 3'b001) && (w_f7 != 7'b0)) ||
                                    ((w_f3 == 3'b101) && (w_f7 != 7'b0) && (w_f7 != c_F7_ALT));
            end
            c_OP_LOAD: begin
                w_dec.alu_src_imm  = 1'b1;
                w_dec.reg_write    = 1'b1;
                w_dec.mem_read     = 1'b1;
                w_dec.mem_width    = w_f3[1:0];
                w_dec.mem_unsigned = w_f3[2];
                w_dec.rs1_used     = 1'b1;
                w_imm32            = w_imm_i;
                w_dec.illegal      = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            c_OP_STORE: begin
                w_dec.alu_src_imm = 1'b1;
                w_dec.mem_write   = 1'b1;
                w_dec.mem_width   = w_f3[1:0];
                w_dec.rs1_used    = 1'b1;
                w_dec.rs2_used    = 1'b1;
                w_imm32           = w_imm_s;
                w_dec.illegal     = (w_f3 > 3'b010);
            end
            c_OP_BRANCH: begin
                w_dec.is_branch   = 1'b1;
                w_dec.branch_type = w_f3;
                w_dec.rs1_used    = 1'b1;
                w_dec.rs2_used    = 1'b1;
                w_imm32           = w_imm_b;
                w_dec.illegal     = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_OP_JAL: begin
                w_dec.alu_src_imm = 1'b1;
                w_dec.alu_src_pc  = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.is_jump     = 1'b1;
                w_imm32           = w_imm_j;
            end
            c_OP_JALR: begin
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.is_jalr     = 1'b1;
                w_dec.rs1_used    = 1'b1;
                w_imm32           = w_imm_i;
                w_dec.illegal     = (w_f3 != 3'b000);
            end
            c_OP_LUI: begin
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.rs1         = 5'd0;
                w_imm32           = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_dec.alu_src_imm = 1'b1;
                w_dec.alu_src_pc  = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_imm32           = w_imm_u;
            end
            default: w_dec.illegal = 1'b1;
        endcase
        w_dec.imm       = XLEN'($signed(w_imm32));
        w_dec.reg_write = w_dec.reg_write && (w_dec.rd != 5'd0);
        // Illegal words keep register fields and immediate but carry no side effects
        if (w_dec.illegal) begin
            w_dec.alu_op       = 4'b0;
            w_dec.alu_src_imm  = 1'b0;
            w_dec.alu_src_pc   = 1'b0;
            w_dec.reg_write    = 1'b0;
            w_dec.mem_read     = 1'b0;
            w_dec.mem_write    = 1'b0;
            w_dec.mem_width    = 2'b0;
            w_dec.mem_unsigned = 1'b0;
            w_dec.is_branch    = 1'b0;
            w_dec.branch_type  = 3'b0;
            w_dec.is_jump      = 1'b0;
            w_dec.is_jalr      = 1'b0;
            w_dec.rs1_used     = 1'b0;
            w_dec.rs2_used     = 1'b0;
        end
    end

    payload_t main_q;
    logic     main_valid_q;
    logic     w_in_fire;

    assign w_in_fire = in_valid && in_ready && !flush;

    if (SKID) begin : g_skid
        payload_t skid_q;
        logic     skid_valid_q;

        assign in_ready = !skid_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_q       <= '0;
                main_valid_q <= 1'b0;
                skid_q       <= '0;
                skid_valid_q <= 1'b0;
            end else if (flush) begin
                main_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
            end else if (!main_valid_q || out_ready) begin
                // in_ready is low whenever the skid entry is occupied
                if (skid_valid_q) begin
                    main_q       <= skid_q;
                    main_valid_q <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else begin
                    main_valid_q <= w_in_fire;
                    if (w_in_fire) begin
                        main_q <= w_dec;
                    end
                end
            end else if (w_in_fire) begin
                skid_q       <= w_dec;
                skid_valid_q <= 1'b1;
            end
        end
    end else begin : g_noskid
        assign in_ready = !main_valid_q || out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_q       <= '0;
                main_valid_q <= 1'b0;
            end else if (flush) begin
                main_valid_q <= 1'b0;
            end else if (in_ready) begin
                main_valid_q <= w_in_fire;
                if (w_in_fire) begin
                    main_q <= w_dec;
                end
            end
        end
    end

    assign out_valid        = main_valid_q;
    assign out_pc           = main_q.pc;
    assign out_alu_op       = main_q.alu_op;
    assign out_alu_src_imm  = main_q.alu_src_imm;
    assign out_alu_src_pc   = main_q.alu_src_pc;
    assign out_reg_write    = main_q.reg_write;
    assign out_mem_read     = main_q.mem_read;
    assign out_mem_write    = main_q.mem_write;
    assign out_mem_width    = main_q.mem_width;
    assign out_mem_unsigned = main_q.mem_unsigned;
    assign out_is_branch    = main_q.is_branch;
    assign out_branch_type  = main_q.branch_type;
    assign out_is_jump      = main_q.is_jump;
    assign out_is_jalr      = main_q.is_jalr;
    assign out_rs1          = main_q.rs1;
    assign out_rs2          = main_q.rs2;
    assign out_rd           = main_q.rd;
    assign out_rs1_used     = main_q.rs1_used;
    assign out_rs2_used     = main_q.rs2_used;
    assign out_imm          = main_q.imm;
    assign out_illegal      = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage (SKID=1 and SKID=0 instances).
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        src_imm;
        logic        src_pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_width;
        logic        mem_unsigned;
        logic        is_branch;
        logic [2:0]  btype;
        logic        is_jump;
        logic        is_jalr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_used;
        logic        rs2_used;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    typedef struct {
        dec_t        d;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        o1_in_ready, o1_valid, o0_in_ready, o0_valid;
    logic [31:0] o1_pc, o0_pc, o1_imm, o0_imm;
    logic [3:0]  o1_alu, o0_alu;
    logic        o1_si, o1_sp, o1_rw, o1_mr, o1_mw, o1_mu, o1_br, o1_j, o1_jr, o1_r1u, o1_r2u, o1_ill;
    logic        o0_si, o0_sp, o0_rw, o0_mr, o0_mw, o0_mu, o0_br, o0_j, o0_jr, o0_r1u, o0_r2u, o0_ill;
    logic [1:0]  o1_mwid, o0_mwid;
    logic [2:0]  o1_bt, o0_bt;
    logic [4:0]  o1_rs1, o1_rs2, o1_rd, o0_rs1, o0_rs2, o0_rd;
    dec_t        got1, got0;

    assign got1 = {o1_alu, o1_si, o1_sp, o1_rw, o1_mr, o1_mw, o1_mwid, o1_mu, o1_br, o1_bt,
                   o1_j, o1_jr, o1_rs1, o1_rs2, o1_rd, o1_r1u, o1_r2u, o1_imm, o1_ill};
    assign got0 = {o0_alu, o0_si, o0_sp, o0_rw, o0_mr, o0_mw, o0_mwid, o0_mu, o0_br, o0_bt,
                   o0_j, o0_jr, o0_rs1, o0_rs2, o0_rd, o0_r1u, o0_r2u, o0_imm, o0_ill};

    decode_stage #(.XLEN(32), .SKID(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(o1_valid), .out_ready(out_ready),
        .out_pc(o1_pc), .out_alu_op(o1_alu), .out_alu_src_imm(o1_si), .out_alu_src_pc(o1_sp),
        .out_reg_write(o1_rw), .out_mem_read(o1_mr), .out_mem_write(o1_mw), .out_mem_width(o1_mwid),
        .out_mem_unsigned(o1_mu), .out_is_branch(o1_br), .out_branch_type(o1_bt), .out_is_jump(o1_j),
        .out_is_jalr(o1_jr), .out_rs1(o1_rs1), .out_rs2(o1_rs2), .out_rd(o1_rd),
        .out_rs1_used(o1_r1u), .out_rs2_used(o1_r2u), .out_imm(o1_imm), .out_illegal(o1_ill)
    );

    decode_stage #(.XLEN(32), .SKID(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(o0_valid), .out_ready(out_ready),
        .out_pc(o0_pc), .out_alu_op(o0_alu), .out_alu_src_imm(o0_si), .out_alu_src_pc(o0_sp),
        .out_reg_write(o0_rw), .out_mem_read(o0_mr), .out_mem_write(o0_mw), .out_mem_width(o0_mwid),
        .out_mem_unsigned(o0_mu), .out_is_branch(o0_br), .out_branch_type(o0_bt), .out_is_jump(o0_j),
        .out_is_jalr(o0_jr), .out_rs1(o0_rs1), .out_rs2(o0_rs2), .out_rd(o0_rd),
        .out_rs1_used(o0_r1u), .out_rs2_used(o0_r2u), .out_imm(o0_imm), .out_illegal(o0_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t q1[$];
    ent_t q0[$];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference decode from the ISA rules: immediates via arithmetic shifts
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t               d;
        logic signed [31:0] s;
        logic [31:0]        top7, sgn;
        int                 f3, f7, alu_base[8];
        bit                 bad, alt;
        alu_base = '{0, 5, 8, 9, 2, 6, 3, 4};
        s    = ins;
        top7 = s >>> 25;
        sgn  = s >>> 31;
        f3   = int'(ins[14:12]);
        f7   = int'(ins[31:25]);
        bad  = 0;
        d    = '0;
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.rd  = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                alt = (f7 == 32) && (f3 == 0 || f3 == 5);
                bad = !(f7 == 0 || alt);
                d.alu_op = 4'(alu_base[f3] + (alt ? 1 : 0));
                d.reg_write = 1; d.rs1_used = 1; d.rs2_used = 1;
            end
            7'h13: begin
                alt = (f3 == 5) && (f7 == 32);
                bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
                d.alu_op = 4'(alu_base[f3] + (alt ? 1 : 0));
                d.src_imm = 1; d.reg_write = 1; d.rs1_used = 1;
                d.imm = s >>> 20;
            end
            7'h03: begin
                bad = (f3 == 3 || f3 == 6 || f3 == 7);
                d.src_imm = 1; d.reg_write = 1; d.mem_read = 1; d.rs1_used = 1;
                d.mem_width = 2'(f3 % 4); d.mem_unsigned = (f3 >= 4);
                d.imm = s >>> 20;
            end
            7'h23: begin
                bad = (f3 > 2);
                d.src_imm = 1; d.mem_write = 1; d.rs1_used = 1; d.rs2_used = 1;
                d.mem_width = 2'(f3 % 4);
                d.imm = (top7 << 5) | 32'(ins[11:7]);
            end
            7'h63: begin
                bad = (f3 == 2 || f3 == 3);
                d.is_branch = 1; d.btype = 3'(f3); d.rs1_used = 1; d.rs2_used = 1;
                d.imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            end
            7'h6F: begin
                d.src_imm = 1; d.src_pc = 1; d.reg_write = 1; d.is_jump = 1;
                d.imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'h67: begin
                bad = (f3 != 0);
                d.src_imm = 1; d.reg_write = 1; d.is_jalr = 1; d.rs1_used = 1;
                d.imm = s >>> 20;
            end
            7'h37: begin
                d.src_imm = 1; d.reg_write = 1; d.rs1 = 0;
                d.imm = ins & 32'hFFFFF000;
            end
            7'h17: begin
                d.src_imm = 1; d.src_pc = 1; d.reg_write = 1;
                d.imm = ins & 32'hFFFFF000;
            end
            default: bad = 1;
        endcase
        if (d.rd == 0) d.reg_write = 0;
        if (bad) begin
            dec_t k;
            k = '0;
            k.rs1 = d.rs1; k.rs2 = d.rs2; k.rd = d.rd; k.imm = d.imm;
            k.illegal = 1;
            d = k;
        end
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[9];
        logic [31:0] r;
        int          sel;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        r   = $urandom();
        sel = $urandom_range(0, 10);
        if (sel < 9) r[6:0] = ops[sel];
        if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return r;
    endfunction

    // One clock: drive inputs, advance the queue models at the edge, compare after it
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bit   acc1, acc0, of1, of0;
        ent_t e;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        e.d  = ref_decode(ins);
        e.pc = pc;
        acc1 = v && (q1.size() < 2) && !fl;
        acc0 = v && (q0.size() == 0 || ordy) && !fl;
        of1  = (q1.size() > 0) && ordy;
        of0  = (q0.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (of1) void'(q1.pop_front());
            if (of0) void'(q0.pop_front());
            if (acc1) q1.push_back(e);
            if (acc0) q0.push_back(e);
        end
        #1;
        chk("out_valid_skid1", 128'(o1_valid), 128'(q1.size() > 0));
        chk("in_ready_skid1", 128'(o1_in_ready), 128'(q1.size() < 2));
        chk("out_valid_skid0", 128'(o0_valid), 128'(q0.size() > 0));
        chk("in_ready_skid0", 128'(o0_in_ready), 128'(q0.size() == 0 || ordy));
        if (q1.size() > 0) begin
            chk("payload_skid1", 128'(got1), 128'(q1[0].d));
            chk("pc_skid1", 128'(o1_pc), 128'(q1[0].pc));
        end
        if (q0.size() > 0) begin
            chk("payload_skid0", 128'(got0), 128'(q0[0].d));
            chk("pc_skid0", 128'(o0_pc), 128'(q0[0].pc));
        end
    endtask

    function automatic dec_t mk(input int alu, input bit si, input bit sp, input bit rw,
                                input bit mr, input bit mw, input int w, input bit u,
                                input bit br, input int bt, input bit j, input bit jr,
                                input int rs1, input int rs2, input int rd, input bit r1u,
                                input bit r2u, input logic [31:0] imm, input bit ill);
        dec_t d;
        d = {4'(alu), si, sp, rw, mr, mw, 2'(w), u, br, 3'(bt), j, jr,
             5'(rs1), 5'(rs2), 5'(rd), r1u, r2u, imm, ill};
        return d;
    endfunction

    initial begin
        vec_t vecs[$];
        vecs.push_back('{32'h002081B3, mk(0,0,0,1,0,0,0,0,0,0,0,0, 1, 2, 3,1,1,32'h0,0)});        // ADD
        vecs.push_back('{32'h4032D293, mk(7,1,0,1,0,0,0,0,0,0,0,0, 5, 3, 5,1,0,32'h403,0)});      // SRAI
        vecs.push_back('{32'h0032D293, mk(6,1,0,1,0,0,0,0,0,0,0,0, 5, 3, 5,1,0,32'h3,0)});        // SRLI
        vecs.push_back('{32'hFE000EE3, mk(0,0,0,0,0,0,0,0,1,0,0,0, 0, 0,29,1,1,32'hFFFFFFFC,0)}); // BEQ -4
        vecs.push_back('{32'h00000000, mk(0,0,0,0,0,0,0,0,0,0,0,0, 0, 0, 0,0,0,32'h0,1)});
        vecs.push_back('{32'h0000707F, mk(0,0,0,0,0,0,0,0,0,0,0,0, 0, 0, 0,0,0,32'h0,1)});
        vecs.push_back('{32'hFF83A303, mk(0,1,0,1,1,0,2,0,0,0,0,0, 7,24, 6,1,0,32'hFFFFFFF8,0)}); // LW
        vecs.push_back('{32'h00415083, mk(0,1,0,1,1,0,1,1,0,0,0,0, 2, 4, 1,1,0,32'h4,0)});        // LHU
        vecs.push_back('{32'h005301A3, mk(0,1,0,0,0,1,0,0,0,0,0,0, 6, 5, 3,1,1,32'h3,0)});        // SB
        vecs.push_back('{32'h12345537, mk(0,1,0,1,0,0,0,0,0,0,0,0, 0, 3,10,0,0,32'h12345000,0)}); // LUI
        vecs.push_back('{32'hFFFFF017, mk(0,1,1,0,0,0,0,0,0,0,0,0,31,31, 0,0,0,32'hFFFFF000,0)}); // AUIPC x0
        vecs.push_back('{32'h001000EF, mk(0,1,1,1,0,0,0,0,0,0,1,0, 0, 1, 1,0,0,32'h800,0)});      // JAL
        vecs.push_back('{32'h000290E7, mk(0,0,0,0,0,0,0,0,0,0,0,0, 5, 0, 1,0,0,32'h0,1)});        // JALR f3!=0
        vecs.push_back('{32'h40520233, mk(1,0,0,1,0,0,0,0,0,0,0,0, 4, 5, 4,1,1,32'h0,0)});        // SUB
        vecs.push_back('{32'hC0008093, mk(0,1,0,1,0,0,0,0,0,0,0,0, 1, 0, 1,1,0,32'hFFFFFC00,0)}); // ADDI no SUBI
        vecs.push_back('{32'h00002063, mk(0,0,0,0,0,0,0,0,0,0,0,0, 0, 0, 0,0,0,32'h0,1)});        // branch f3 010
        vecs.push_back('{32'h02009093, mk(0,0,0,0,0,0,0,0,0,0,0,0, 1, 0, 1,0,0,32'h20,1)});       // SLLI bad f7

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid1", 128'(o1_valid), 128'(0));
        chk("reset_in_ready1", 128'(o1_in_ready), 128'(1));
        chk("reset_payload1", 128'(got1), 128'(0));
        chk("reset_pc1", 128'(o1_pc), 128'(0));
        chk("reset_out_valid0", 128'(o0_valid), 128'(0));
        chk("reset_in_ready0", 128'(o0_in_ready), 128'(1));
        chk("reset_payload0", 128'(got0), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
            chk($sformatf("table_%0d_%08h", i, vecs[i].instr), 128'(got1), 128'(vecs[i].exp));
            chk($sformatf("table_pc_%0d", i), 128'(o1_pc), 128'(32'h1000 + 32'(i * 4)));
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Skid fill: third offer refused, then drain in order
        cycle(1'b1, 32'h002081B3, 32'hA000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0032D293, 32'hA004, 1'b0, 1'b0);
        cycle(1'b1, 32'hFE000EE3, 32'hA008, 1'b0, 1'b0);
        chk("skid_full_in_ready", 128'(o1_in_ready), 128'(0));
        chk("stall_hold_pc", 128'(o1_pc), 128'(32'hA000));
        cycle(1'b1, 32'hFE000EE3, 32'hA008, 1'b1, 1'b0);
        chk("drain_second_pc", 128'(o1_pc), 128'(32'hA004));
        cycle(1'b1, 32'hFE000EE3, 32'hA008, 1'b1, 1'b0);
        chk("drain_third_pc", 128'(o1_pc), 128'(32'hA008));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with main and skid full and a simultaneous offer
        cycle(1'b1, 32'h40520233, 32'hB000, 1'b0, 1'b0);
        cycle(1'b1, 32'h00415083, 32'hB004, 1'b0, 1'b0);
        cycle(1'b1, 32'h12345537, 32'hB008, 1'b1, 1'b1);
        chk("flush_out_valid", 128'(o1_valid), 128'(0));
        chk("flush_in_ready", 128'(o1_in_ready), 128'(1));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("post_flush_empty", 128'(o1_valid), 128'(0));

        // Asynchronous reset in the middle of a stall
        cycle(1'b1, 32'h001000EF, 32'hC000, 1'b0, 1'b0);
        cycle(1'b1, 32'h005301A3, 32'hC004, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid1", 128'(o1_valid), 128'(0));
        chk("async_rst_out_valid0", 128'(o0_valid), 128'(0));
        chk("async_rst_in_ready1", 128'(o1_in_ready), 128'(1));
        chk("async_rst_payload1", 128'(got1), 128'(0));
        q1.delete();
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom(),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
